// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit and its ALU.
// Opcode, funct, ALU-op, state and mux-select values live here.
package mips_ctrl_pkg;

   localparam int unsigned RA_INDEX = 31;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_I_EXEC    = 4'd10,
      S_I_WB      = 4'd11,
      S_JR        = 4'd12
   } state_t;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111,
      ALU_NOR = 4'b1100,
      ALU_SLL = 4'b1101,
      ALU_SRL = 4'b1110
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;

   localparam logic [5:0] FN_ADD  = 6'b100000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUB  = 6'b100010;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_NOR  = 6'b100111;
   localparam logic [5:0] FN_SLT  = 6'b101010;
   localparam logic [5:0] FN_SLL  = 6'b000000;
   localparam logic [5:0] FN_SRL  = 6'b000010;
   localparam logic [5:0] FN_JR   = 6'b001000;

   localparam logic [1:0] SRC_A_PC  = 2'b00;
   localparam logic [1:0] SRC_A_REG = 2'b01;
   localparam logic [1:0] SRC_A_B   = 2'b10;

   localparam logic [1:0] SRC_B_REG  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;
   localparam logic [1:0] SRC_B_BR   = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_REG    = 2'b11;

   localparam logic [1:0] DST_RT = 2'b00;
   localparam logic [1:0] DST_RD = 2'b01;
   localparam logic [1:0] DST_RA = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MDR = 2'b01;
   localparam logic [1:0] WB_PC  = 2'b10;

   function automatic logic opcode_ok(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
         OP_J, OP_JAL, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_ANDI, OP_ORI: return 1'b1;
         default:         return 1'b0;
      endcase
   endfunction

   function automatic logic funct_ok(input logic [5:0] fn);
      case (fn)
         FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND,
         FN_OR, FN_NOR, FN_SLT, FN_SLL, FN_SRL,
         FN_JR:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control/datapath bundle: IR fields and zero flag in,
// ALU control, mux selects and enables out.
interface mips_multicycle_control_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       alu_zero;
   logic [3:0] alu_op;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic       ext_zero;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic [1:0] reg_dst;
   logic [1:0] mem_to_reg;
   logic       instr_done;
   logic       illegal;
   logic [3:0] state;

   modport master (
      input  opcode, funct, alu_zero,
      output alu_op, alu_src_a, alu_src_b, ext_zero,
      output pc_write, pc_src, iord, mem_read, mem_write,
      output ir_write, reg_write, reg_dst, mem_to_reg,
      output instr_done, illegal, state
   );

   modport slave (
      output opcode, funct, alu_zero,
      input  alu_op, alu_src_a, alu_src_b, ext_zero,
      input  pc_write, pc_src, iord, mem_read, mem_write,
      input  ir_write, reg_write, reg_dst, mem_to_reg,
      input  instr_done, illegal, state
   );
endinterface

// File: rtl/mips_alu_op_decode.sv
// ALU operation and operand selection for each control state.
// Shared ALU does PC+4, branch target, address and execute.
module mips_alu_op_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output alu_op_t    alu_op,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic       ext_zero
);

   always_comb begin
      alu_op    = ALU_AND;
      alu_src_a = SRC_A_PC;
      alu_src_b = SRC_B_REG;
      ext_zero  = 1'b0;
      unique case (state)
         S_FETCH: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_B_FOUR;
         end
         S_DECODE: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRC_B_BR;
         end
         S_MEM_ADDR: begin
            alu_op    = ALU_ADD;
            alu_src_a = SRC_A_REG;
            alu_src_b = SRC_B_IMM;
         end
         S_R_EXEC: begin
            alu_src_a = SRC_A_REG;
            case (funct)
               FN_ADD, FN_ADDU: alu_op = ALU_ADD;
               FN_SUB, FN_SUBU: alu_op = ALU_SUB;
               FN_AND:          alu_op = ALU_AND;
               FN_OR:           alu_op = ALU_OR;
               FN_NOR:          alu_op = ALU_NOR;
               FN_SLT:          alu_op = ALU_SLT;
               // shifts operate on rt, which sits in B
               FN_SLL: begin
                  alu_op    = ALU_SLL;
                  alu_src_a = SRC_A_B;
               end
               FN_SRL: begin
                  alu_op    = ALU_SRL;
                  alu_src_a = SRC_A_B;
               end
               default: ;
            endcase
         end
         S_BRANCH: begin
            alu_op    = ALU_SUB;
            alu_src_a = SRC_A_REG;
         end
         S_I_EXEC, S_I_WB: begin
            alu_src_a = SRC_A_REG;
            alu_src_b = SRC_B_IMM;
            case (opcode)
               OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
               OP_SLTI:           alu_op = ALU_SLT;
               OP_ANDI: begin
                  alu_op   = ALU_AND;
                  ext_zero = 1'b1;
               end
               OP_ORI: begin
                  alu_op   = ALU_OR;
                  ext_zero = 1'b1;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: sequences 3-5 cycle instructions
// and drives every datapath enable and mux select.
module mips_multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   mips_multicycle_control_if.master  bus
);

   state_t     state_q;
   state_t     state_d;
   logic [5:0] op_q;
   logic [5:0] fn_q;

   alu_op_t    alu_op;
   logic [1:0] src_a;
   logic [1:0] src_b;
   logic       ext;
   logic       pcw;
   logic [1:0] pcs;
   logic       iord;
   logic       mr;
   logic       mw;
   logic       irw;
   logic       rw;
   logic [1:0] rd;
   logic [1:0] m2r;
   logic       done;
   logic       ill;
   logic       bad;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         op_q    <= '0;
         fn_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
         end
      end
   end

   mips_alu_op_decode u_alu_dec (
      .state     (state_q),
      .opcode    (op_q),
      .funct     (fn_q),
      .alu_op    (alu_op),
      .alu_src_a (src_a),
      .alu_src_b (src_b),
      .ext_zero  (ext)
   );

   assign bad = !opcode_ok(bus.opcode) ||
                (bus.opcode == OP_RTYPE && !funct_ok(bus.funct));

   always_comb begin
      state_d = S_FETCH;
      pcw     = 1'b0;
      pcs     = PC_ALU;
      iord    = 1'b0;
      mr      = 1'b0;
      mw      = 1'b0;
      irw     = 1'b0;
      rw      = 1'b0;
      rd      = DST_RT;
      m2r     = WB_ALU;
      done    = 1'b0;
      ill     = 1'b0;
      unique case (state_q)
         S_FETCH: begin
            mr      = 1'b1;
            irw     = 1'b1;
            pcw     = 1'b1;
            state_d = S_DECODE;
         end
         // DECODE looks at the live IR; later states use op_q/fn_q
         S_DECODE: begin
            if (bad) begin
               ill = 1'b1;
            end else begin
               case (bus.opcode)
                  OP_RTYPE:
                     state_d = (bus.funct == FN_JR) ? S_JR : S_R_EXEC;
                  OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                  OP_BEQ, OP_BNE: state_d = S_BRANCH;
                  OP_J, OP_JAL:   state_d = S_JUMP;
                  OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI:
                     state_d = S_I_EXEC;
                  default:        state_d = S_FETCH;
               endcase
            end
         end
         S_MEM_ADDR:
            state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ: begin
            mr      = 1'b1;
            iord    = 1'b1;
            state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            rw   = 1'b1;
            m2r  = WB_MDR;
            done = 1'b1;
         end
         S_MEM_WRITE: begin
            mw   = 1'b1;
            iord = 1'b1;
            done = 1'b1;
         end
         S_R_EXEC: state_d = S_R_WB;
         S_R_WB: begin
            rw   = 1'b1;
            rd   = DST_RD;
            done = 1'b1;
         end
         S_BRANCH: begin
            pcs  = PC_ALUOUT;
            pcw  = (op_q == OP_BNE) ? ~bus.alu_zero : bus.alu_zero;
            done = 1'b1;
         end
         S_JUMP: begin
            pcs  = PC_JUMP;
            pcw  = 1'b1;
            done = 1'b1;
            if (op_q == OP_JAL) begin
               rw  = 1'b1;
               rd  = DST_RA;
               m2r = WB_PC;
            end
         end
         S_JR: begin
            pcs  = PC_REG;
            pcw  = 1'b1;
            done = 1'b1;
         end
         S_I_EXEC: state_d = S_I_WB;
         S_I_WB: begin
            rw   = 1'b1;
            done = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase
   end

   // everything is forced quiet while reset is held
   assign bus.alu_op     = reset ? 4'b0000 : alu_op;
   assign bus.alu_src_a  = reset ? 2'b00 : src_a;
   assign bus.alu_src_b  = reset ? 2'b00 : src_b;
   assign bus.ext_zero   = ~reset & ext;
   assign bus.pc_write   = ~reset & pcw;
   assign bus.pc_src     = reset ? 2'b00 : pcs;
   assign bus.iord       = ~reset & iord;
   assign bus.mem_read   = ~reset & mr;
   assign bus.mem_write  = ~reset & mw;
   assign bus.ir_write   = ~reset & irw;
   assign bus.reg_write  = ~reset & rw;
   assign bus.reg_dst    = reset ? 2'b00 : rd;
   assign bus.mem_to_reg = reset ? 2'b00 : m2r;
   assign bus.instr_done = ~reset & done;
   assign bus.illegal    = ~reset & ill;
   assign bus.state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for the multicycle MIPS control FSM.
// Stimulus queues per-cycle expected outputs; a monitor checks them.
module tb_mips_multicycle_control;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] aop;
      logic [1:0] sa;
      logic [1:0] sb;
      logic       ext;
      logic       pcw;
      logic [1:0] pcs;
      logic       iord;
      logic       mr;
      logic       mw;
      logic       irw;
      logic       rw;
      logic [1:0] rd;
      logic [1:0] m2r;
      logic       done;
      logic       ill;
   } vec_t;

   typedef struct {
      vec_t  v;
      string nm;
   } exp_t;

   logic clk;
   logic reset;
   exp_t q[$];
   int   n_vec;
   int   n_bad;

   mips_multicycle_control_if bus ();

   mips_multicycle_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic [3:0] st, input logic [3:0] aop,
      input logic [1:0] sa, input logic [1:0] sb, input logic ext,
      input logic pcw, input logic [1:0] pcs, input logic iord,
      input logic mr, input logic mw, input logic irw,
      input logic rw, input logic [1:0] rd, input logic [1:0] m2r,
      input logic done, input logic ill);
      vec_t r;
      r = '{st, aop, sa, sb, ext, pcw, pcs, iord, mr, mw, irw,
            rw, rd, m2r, done, ill};
      return r;
   endfunction

   //                  st aop      sa sb e pw ps io mr mw ir rw rd m2 dn il
   localparam vec_t ZERO = '0;
   vec_t F, D, DI;

   task automatic push(input vec_t v, input string nm);
      exp_t e;
      e.v  = v;
      e.nm = nm;
      q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set(input logic [5:0] op, input logic [5:0] fn,
                      input logic z);
      bus.opcode   = op;
      bus.funct    = fn;
      bus.alu_zero = z;
   endtask

   always @(negedge clk) begin
      vec_t got;
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         got = '{bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b,
                 bus.ext_zero, bus.pc_write, bus.pc_src, bus.iord,
                 bus.mem_read, bus.mem_write, bus.ir_write,
                 bus.reg_write, bus.reg_dst, bus.mem_to_reg,
                 bus.instr_done, bus.illegal};
         n_vec++;
         if (got !== e.v) begin
            n_bad++;
            $display("FAIL %s: got %b required %b", e.nm, got, e.v);
         end
      end
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      F  = mk(0, 4'b0010, 0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
      D  = mk(1, 4'b0010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      DI = mk(1, 4'b0010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      reset = 1'b1;
      set(6'b000000, 6'b100000, 1'b0);
      @(posedge clk);
      #1;
      push(ZERO, "reset0");
      push(ZERO, "reset1");
      push(ZERO, "reset2");
      cycles(3);
      reset = 1'b0;

      // sub
      set(6'b000000, 6'b100010, 1'b0);
      push(F, "sub.fetch");
      push(D, "sub.dec");
      push(mk(6, 4'b0110, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "sub.exec");
      push(mk(7, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0),
           "sub.wb");
      cycles(4);

      // lw, with IR scrambled after decode
      set(6'b100011, 6'b000000, 1'b0);
      push(F, "lw.fetch");
      push(D, "lw.dec");
      push(mk(2, 4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "lw.addr");
      push(mk(3, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0),
           "lw.read");
      push(mk(4, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0),
           "lw.wb");
      cycles(2);
      set(6'b101011, 6'b111111, 1'b1);
      cycles(3);

      // sw
      set(6'b101011, 6'b000000, 1'b0);
      push(F, "sw.fetch");
      push(D, "sw.dec");
      push(mk(2, 4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "sw.addr");
      push(mk(5, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0),
           "sw.write");
      cycles(4);

      // beq taken, beq not taken, bne taken
      set(6'b000100, 6'b000000, 1'b1);
      push(F, "beq1.fetch");
      push(D, "beq1.dec");
      push(mk(8, 4'b0110, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           "beq1.br");
      cycles(3);
      set(6'b000100, 6'b000000, 1'b0);
      push(F, "beq0.fetch");
      push(D, "beq0.dec");
      push(mk(8, 4'b0110, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           "beq0.br");
      cycles(3);
      set(6'b000101, 6'b000000, 1'b0);
      push(F, "bne0.fetch");
      push(D, "bne0.dec");
      push(mk(8, 4'b0110, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           "bne0.br");
      cycles(3);

      // jal, j, jr, sll
      set(6'b000011, 6'b000000, 1'b0);
      push(F, "jal.fetch");
      push(D, "jal.dec");
      push(mk(9, 4'b0000, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2, 2, 1, 0),
           "jal.jump");
      cycles(3);
      set(6'b000010, 6'b000000, 1'b0);
      push(F, "j.fetch");
      push(D, "j.dec");
      push(mk(9, 4'b0000, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           "j.jump");
      cycles(3);
      set(6'b000000, 6'b001000, 1'b0);
      push(F, "jr.fetch");
      push(D, "jr.dec");
      push(mk(12, 4'b0000, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0),
           "jr.jr");
      cycles(3);
      set(6'b000000, 6'b000000, 1'b0);
      push(F, "sll.fetch");
      push(D, "sll.dec");
      push(mk(6, 4'b1101, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "sll.exec");
      push(mk(7, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0),
           "sll.wb");
      cycles(4);

      // andi and slti
      set(6'b001100, 6'b000000, 1'b0);
      push(F, "andi.fetch");
      push(D, "andi.dec");
      push(mk(10, 4'b0000, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "andi.exec");
      push(mk(11, 4'b0000, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),
           "andi.wb");
      cycles(4);
      set(6'b001010, 6'b000000, 1'b0);
      push(F, "slti.fetch");
      push(D, "slti.dec");
      push(mk(10, 4'b0111, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "slti.exec");
      push(mk(11, 4'b0111, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),
           "slti.wb");
      cycles(4);

      // illegal opcode and illegal funct
      set(6'b111111, 6'b000000, 1'b0);
      push(F, "illop.fetch");
      push(DI, "illop.dec");
      cycles(2);
      set(6'b000000, 6'b111111, 1'b0);
      push(F, "illfn.fetch");
      push(DI, "illfn.dec");
      cycles(2);

      // reset asserted during MEM_READ
      set(6'b100011, 6'b000000, 1'b0);
      push(F, "rst.fetch");
      push(D, "rst.dec");
      push(mk(2, 4'b0010, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "rst.addr");
      cycles(3);
      reset = 1'b1;
      push(ZERO, "rst.hold");
      cycles(1);
      reset = 1'b0;

      // ori right after reset
      set(6'b001101, 6'b000000, 1'b0);
      push(F, "ori.fetch");
      push(D, "ori.dec");
      push(mk(10, 4'b0001, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
           "ori.exec");
      push(mk(11, 4'b0001, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0),
           "ori.wb");
      cycles(4);

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d left, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
